imem_load_run_ctrl: RTL and testbench

Control unit that owns the IF-stage instruction-memory write port and the pipeline-wide stall/reset lines. It accepts LOAD, RUN, STEP and HALT commands over a valid/ready interface. It streams program words into instruction memory at sequential byte addresses, flushes the pipeline, then runs free, single-steps or halts it. It sits between the host/debug link and the IF, IF_ID, ID and ID_EX stages.

---
 rtl/imem_load_run_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_imem_load_run_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_run_ctrl.sv
// Host-facing loader and run/step/halt sequencer for the IF-stage instruction memory and pipeline control lines.
// Optional run watchdog is compiled in when IMEM_CTRL_WATCHDOG_EN is defined.

module imem_load_run_ctrl #(
   parameter int unsigned IMEM_DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR      = 32'h0,
   parameter int unsigned FLUSH_CYCLES   = 2,
   parameter int unsigned DRAIN_CYCLES   = 4,
   parameter logic [31:0] MAX_RUN_CYCLES = 32'hFFFF
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_cmd_valid,
   input  logic [1:0]                    i_cmd,
   input  logic [$clog2(IMEM_DEPTH):0]   i_cmd_len,
   output logic                          o_cmd_ready,
   output logic                          o_cmd_err,
   input  logic                          i_word_valid,
   input  logic [31:0]                   i_word,
   output logic                          o_word_ready,
   output logic                          o_imem_write_en,
   output logic                          o_imem_read_en,
   output logic [31:0]                   o_imem_addr,
   output logic [31:0]                   o_imem_data,
   output logic                          o_pipe_stall,
   output logic                          o_pipe_reset,
   input  logic                          i_halt_detected,
   output logic [2:0]                    o_state,
   output logic                          o_done,
   output logic [31:0]                   o_cycle_count,
   output logic                          o_timeout
);

   localparam int unsigned LEN_W = $clog2(IMEM_DEPTH) + 1;

   localparam logic [1:0] CMD_LOAD = 2'b00;
   localparam logic [1:0] CMD_RUN  = 2'b01;
   localparam logic [1:0] CMD_STEP = 2'b10;
   localparam logic [1:0] CMD_HALT = 2'b11;

`ifdef IMEM_CTRL_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_CLEAR  = 3'd2,
      ST_RUN    = 3'd3,
      ST_STEP   = 3'd4,
      ST_DRAIN  = 3'd5,
      ST_HALTED = 3'd6
   } state_t;

   state_t             state_r, state_nx_s;
   state_t             tgt_r, tgt_nx_s;
   logic [LEN_W-1:0]   idx_r, idx_nx_s;
   logic [LEN_W-1:0]   len_r, len_nx_s;
   logic [31:0]        flush_cnt_r, flush_cnt_nx_s;
   logic [31:0]        drain_cnt_r, drain_cnt_nx_s;
   logic [31:0]        count_r, count_nx_s;
   logic               timeout_r, timeout_nx_s;
   logic               cmd_ready_r, word_ready_r, word_ready_nx_s;
   logic               we_r, we_nx_s;
   logic               re_r, stall_r, pipe_reset_r;
   logic [31:0]        addr_r, addr_nx_s;
   logic [31:0]        data_r, data_nx_s;
   logic               done_r, done_nx_s;
   logic               err_r, err_nx_s;

   logic               cmd_acc_s, word_acc_s, wd_trip_s;
   logic               run_like_s, run_like_nx_s;
   logic [31:0]        count_inc_s;

   assign cmd_acc_s     = i_cmd_valid & cmd_ready_r;
   assign word_acc_s    = i_word_valid & word_ready_r;
   assign count_inc_s   = (count_r == 32'hFFFF_FFFF) ? count_r : (count_r + 32'd1);
   assign wd_trip_s     = WD_EN && (count_inc_s >= MAX_RUN_CYCLES);
   assign run_like_s    = (state_r == ST_RUN) || (state_r == ST_STEP) || (state_r == ST_DRAIN);
   assign run_like_nx_s = (state_nx_s == ST_RUN) || (state_nx_s == ST_STEP) || (state_nx_s == ST_DRAIN);

   // Next-state, counters and write-port command decode
   always_comb begin
      state_nx_s     = state_r;
      tgt_nx_s       = tgt_r;
      idx_nx_s       = idx_r;
      len_nx_s       = len_r;
      flush_cnt_nx_s = flush_cnt_r;
      drain_cnt_nx_s = drain_cnt_r;
      timeout_nx_s   = timeout_r;
      we_nx_s        = 1'b0;
      addr_nx_s      = addr_r;
      data_nx_s      = data_r;
      done_nx_s      = 1'b0;
      err_nx_s       = 1'b0;
      count_nx_s     = count_r;

      case (state_r)
         ST_IDLE, ST_HALTED: begin
            if (cmd_acc_s) begin
               if (i_cmd != CMD_HALT) begin
                  timeout_nx_s = 1'b0;
               end else begin
                  timeout_nx_s = timeout_r;
               end
               case (i_cmd)
                  CMD_LOAD: begin
                     if (i_cmd_len == {LEN_W{1'b0}}) begin
                        done_nx_s = 1'b1;
                     end else if (32'(i_cmd_len) > IMEM_DEPTH) begin
                        err_nx_s = 1'b1;
                     end else begin
                        state_nx_s = ST_LOAD;
                        idx_nx_s   = {LEN_W{1'b0}};
                        len_nx_s   = i_cmd_len;
                     end
                  end
                  CMD_RUN, CMD_STEP: begin
                     // Leaving HALTED resumes the preserved pipeline; leaving IDLE flushes it first
                     if (state_r == ST_HALTED) begin
                        state_nx_s = (i_cmd == CMD_RUN) ? ST_RUN : ST_STEP;
                     end else begin
                        state_nx_s     = ST_CLEAR;
                        tgt_nx_s       = (i_cmd == CMD_RUN) ? ST_RUN : ST_STEP;
                        flush_cnt_nx_s = 32'd0;
                     end
                  end
                  CMD_HALT: state_nx_s = state_r;
                  default:  state_nx_s = state_r;
               endcase
            end else begin
               state_nx_s = state_r;
            end
         end

         ST_LOAD: begin
            // idx==len means the last word's write is on the port this cycle
            if (idx_r == len_r) begin
               state_nx_s     = ST_CLEAR;
               tgt_nx_s       = ST_IDLE;
               flush_cnt_nx_s = 32'd0;
            end else if (word_acc_s) begin
               we_nx_s   = 1'b1;
               addr_nx_s = BASE_ADDR + {{(32-LEN_W-2){1'b0}}, idx_r, 2'b00};
               data_nx_s = i_word;
               idx_nx_s  = idx_r + {{(LEN_W-1){1'b0}}, 1'b1};
            end else begin
               state_nx_s = ST_LOAD;
            end
         end

         ST_CLEAR: begin
            if (flush_cnt_r == (FLUSH_CYCLES - 32'd1)) begin
               state_nx_s = tgt_r;
               done_nx_s  = (tgt_r == ST_IDLE);
            end else begin
               flush_cnt_nx_s = flush_cnt_r + 32'd1;
            end
         end

         ST_RUN: begin
            // An explicit HALT outranks both the watchdog and a decoded halt instruction
            if (cmd_acc_s && (i_cmd == CMD_HALT)) begin
               state_nx_s = ST_HALTED;
               done_nx_s  = 1'b1;
            end else begin
               err_nx_s = cmd_acc_s;
               if (wd_trip_s) begin
                  state_nx_s   = ST_HALTED;
                  done_nx_s    = 1'b1;
                  timeout_nx_s = 1'b1;
               end else if (i_halt_detected) begin
                  if (DRAIN_CYCLES == 0) begin
                     state_nx_s = ST_HALTED;
                     done_nx_s  = 1'b1;
                  end else begin
                     state_nx_s     = ST_DRAIN;
                     drain_cnt_nx_s = 32'd0;
                  end
               end else begin
                  state_nx_s = ST_RUN;
               end
            end
         end

         ST_DRAIN: begin
            if (drain_cnt_r == (DRAIN_CYCLES - 32'd1)) begin
               state_nx_s = ST_HALTED;
               done_nx_s  = 1'b1;
            end else begin
               drain_cnt_nx_s = drain_cnt_r + 32'd1;
            end
         end

         ST_STEP: begin
            state_nx_s = ST_HALTED;
            done_nx_s  = 1'b1;
         end

         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase

      if (state_nx_s == ST_CLEAR) begin
         count_nx_s = 32'd0;
      end else if (run_like_s) begin
         count_nx_s = count_inc_s;
      end else begin
         count_nx_s = count_r;
      end

      word_ready_nx_s = (state_nx_s == ST_LOAD) && (idx_nx_s != len_nx_s);
   end

   // State, counters and registered outputs, all timed to the next state
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_r      <= ST_IDLE;
         tgt_r        <= ST_IDLE;
         idx_r        <= {LEN_W{1'b0}};
         len_r        <= {LEN_W{1'b0}};
         flush_cnt_r  <= 32'd0;
         drain_cnt_r  <= 32'd0;
         count_r      <= 32'd0;
         timeout_r    <= 1'b0;
         cmd_ready_r  <= 1'b1;
         word_ready_r <= 1'b0;
         we_r         <= 1'b0;
         re_r         <= 1'b0;
         stall_r      <= 1'b1;
         pipe_reset_r <= 1'b0;
         addr_r       <= 32'd0;
         data_r       <= 32'd0;
         done_r       <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         tgt_r        <= tgt_nx_s;
         idx_r        <= idx_nx_s;
         len_r        <= len_nx_s;
         flush_cnt_r  <= flush_cnt_nx_s;
         drain_cnt_r  <= drain_cnt_nx_s;
         count_r      <= count_nx_s;
         timeout_r    <= timeout_nx_s;
         cmd_ready_r  <= (state_nx_s == ST_IDLE) || (state_nx_s == ST_HALTED) || (state_nx_s == ST_RUN);
         word_ready_r <= word_ready_nx_s;
         we_r         <= we_nx_s;
         re_r         <= run_like_nx_s;
         stall_r      <= !run_like_nx_s;
         pipe_reset_r <= (state_nx_s == ST_CLEAR);
         addr_r       <= addr_nx_s;
         data_r       <= data_nx_s;
         done_r       <= done_nx_s;
         err_r        <= err_nx_s;
      end
   end

   assign o_state         = state_r;
   assign o_cmd_ready     = cmd_ready_r;
   assign o_cmd_err       = err_r;
   assign o_word_ready    = word_ready_r;
   assign o_imem_write_en = we_r;
   assign o_imem_read_en  = re_r;
   assign o_imem_addr     = addr_r;
   assign o_imem_data     = data_r;
   assign o_pipe_stall    = stall_r;
   assign o_pipe_reset    = pipe_reset_r;
   assign o_done          = done_r;
   assign o_cycle_count   = count_r;

`ifdef IMEM_CTRL_WATCHDOG_EN
   assign o_timeout = timeout_r;
`else
   assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_imem_load_run_ctrl.sv
// Directed bench for imem_load_run_ctrl: vector table for load/command decode plus
// hand-written run, drain, step, reset-during-load and watchdog sequences.

module tb_imem_load_run_ctrl;

   localparam logic [1:0] LOAD = 2'b00;
   localparam logic [1:0] RUN  = 2'b01;
   localparam logic [1:0] STEP = 2'b10;
   localparam logic [1:0] HALT = 2'b11;
   localparam logic [31:0] W0 = 32'h014B4820;
   localparam logic [31:0] W1 = 32'h8C080004;
   localparam logic [31:0] W2 = 32'hAC090008;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic [1:0]  cmd;
   logic [8:0]  cmd_len;
   logic        cmd_ready;
   logic        cmd_err;
   logic        word_valid;
   logic [31:0] word;
   logic        word_ready;
   logic        we;
   logic        re;
   logic [31:0] addr;
   logic [31:0] data;
   logic        stall;
   logic        prst;
   logic        halt_det;
   logic [2:0]  st;
   logic        done;
   logic [31:0] count;
   logic        timeout;

   int checks;
   int errors;

   typedef struct {
      logic        cv;
      logic [1:0]  c;
      logic [8:0]  len;
      logic        wv;
      logic [31:0] w;
      logic [2:0]  e_st;
      logic        e_we;
      logic [31:0] e_addr;
      logic [31:0] e_data;
      logic        e_stall;
      logic        e_prst;
      logic        e_done;
      logic        e_err;
      logic        e_crdy;
      logic        e_wrdy;
   } vec_t;

   vec_t tbl[12];

   imem_load_run_ctrl #(
      .IMEM_DEPTH(256),
      .BASE_ADDR(32'h0),
      .FLUSH_CYCLES(2),
      .DRAIN_CYCLES(4),
      .MAX_RUN_CYCLES(32'd20)
   ) dut (
      .i_clk(clk),
      .i_reset(rst_n),
      .i_cmd_valid(cmd_valid),
      .i_cmd(cmd),
      .i_cmd_len(cmd_len),
      .o_cmd_ready(cmd_ready),
      .o_cmd_err(cmd_err),
      .i_word_valid(word_valid),
      .i_word(word),
      .o_word_ready(word_ready),
      .o_imem_write_en(we),
      .o_imem_read_en(re),
      .o_imem_addr(addr),
      .o_imem_data(data),
      .o_pipe_stall(stall),
      .o_pipe_reset(prst),
      .i_halt_detected(halt_det),
      .o_state(st),
      .o_done(done),
      .o_cycle_count(count),
      .o_timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic cv, input logic [1:0] c, input logic [8:0] len,
                               input logic wv, input logic [31:0] w, input logic [2:0] e_st,
                               input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_data,
                               input logic e_stall, input logic e_prst, input logic e_done,
                               input logic e_err, input logic e_crdy, input logic e_wrdy);
      vec_t v;
      v.cv = cv; v.c = c; v.len = len; v.wv = wv; v.w = w;
      v.e_st = e_st; v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
      v.e_stall = e_stall; v.e_prst = e_prst; v.e_done = e_done; v.e_err = e_err;
      v.e_crdy = e_crdy; v.e_wrdy = e_wrdy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd = LOAD; cmd_len = 9'd0;
      word_valid = 1'b0; word = 32'd0; halt_det = 1'b0;

      tbl[0]  = mk(1'b1, LOAD, 9'd3,   1'b0, 32'd0, 3'd1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[1]  = mk(1'b0, LOAD, 9'd0,   1'b1, W0,    3'd1, 1'b1, 32'd0, W0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[2]  = mk(1'b0, LOAD, 9'd0,   1'b1, W1,    3'd1, 1'b1, 32'd4, W1,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tbl[3]  = mk(1'b0, LOAD, 9'd0,   1'b1, W2,    3'd1, 1'b1, 32'd8, W2,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[4]  = mk(1'b0, LOAD, 9'd0,   1'b0, 32'd0, 3'd2, 1'b0, 32'd8, W2,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[5]  = mk(1'b0, LOAD, 9'd0,   1'b0, 32'd0, 3'd2, 1'b0, 32'd8, W2,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[6]  = mk(1'b0, LOAD, 9'd0,   1'b0, 32'd0, 3'd0, 1'b0, 32'd8, W2,    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tbl[7]  = mk(1'b0, LOAD, 9'd0,   1'b0, 32'd0, 3'd0, 1'b0, 32'd8, W2,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tbl[8]  = mk(1'b1, LOAD, 9'd257, 1'b0, 32'd0, 3'd0, 1'b0, 32'd8, W2,    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tbl[9]  = mk(1'b0, LOAD, 9'd0,   1'b0, 32'd0, 3'd0, 1'b0, 32'd8, W2,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tbl[10] = mk(1'b1, LOAD, 9'd0,   1'b0, 32'd0, 3'd0, 1'b0, 32'd8, W2,    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tbl[11] = mk(1'b0, LOAD, 9'd0,   1'b0, 32'd0, 3'd0, 1'b0, 32'd8, W2,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Reset values
      #12;
      chk("rst_state", st, 3'd0);
      chk("rst_stall", stall, 1'b1);
      chk("rst_we", we, 1'b0);
      chk("rst_count", count, 32'd0);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_prst", prst, 1'b0);
      chk("rst_done_err_to", {done, cmd_err, timeout, re, word_ready}, 5'd0);
      chk("rst_addr", addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Table: LOAD of three words, bad length, zero length
      for (int i = 0; i < 12; i++) begin
         cmd_valid  = tbl[i].cv;
         cmd        = tbl[i].c;
         cmd_len    = tbl[i].len;
         word_valid = tbl[i].wv;
         word       = tbl[i].w;
         tick();
         chk($sformatf("row%0d_state", i), st, tbl[i].e_st);
         chk($sformatf("row%0d_we", i), we, tbl[i].e_we);
         chk($sformatf("row%0d_addr", i), addr, tbl[i].e_addr);
         chk($sformatf("row%0d_data", i), data, tbl[i].e_data);
         chk($sformatf("row%0d_stall", i), stall, tbl[i].e_stall);
         chk($sformatf("row%0d_re", i), re, !tbl[i].e_stall);
         chk($sformatf("row%0d_prst", i), prst, tbl[i].e_prst);
         chk($sformatf("row%0d_done", i), done, tbl[i].e_done);
         chk($sformatf("row%0d_err", i), cmd_err, tbl[i].e_err);
         chk($sformatf("row%0d_cmd_ready", i), cmd_ready, tbl[i].e_crdy);
         chk($sformatf("row%0d_word_ready", i), word_ready, tbl[i].e_wrdy);
      end
      cmd_valid = 1'b0; word_valid = 1'b0;

      // LOAD len=2 with a three-cycle gap between words
      cmd_valid = 1'b1; cmd = LOAD; cmd_len = 9'd2;
      tick();
      cmd_valid = 1'b0;
      chk("gap_state_load", st, 3'd1);
      word_valid = 1'b1; word = 32'h11111111;
      tick();
      chk("gap_w0_we", we, 1'b1);
      chk("gap_w0_addr", addr, 32'd0);
      chk("gap_w0_data", data, 32'h11111111);
      word_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
         tick();
         chk($sformatf("gap_idle%0d_we", g), we, 1'b0);
      end
      word_valid = 1'b1; word = 32'h22222222;
      tick();
      chk("gap_w1_we", we, 1'b1);
      chk("gap_w1_addr", addr, 32'd4);
      chk("gap_w1_data", data, 32'h22222222);
      chk("gap_w1_wrdy", word_ready, 1'b0);
      tick();
      word_valid = 1'b0;
      chk("gap_clear_state", st, 3'd2);
      chk("gap_clear_we", we, 1'b0);
      tick();
      tick();
      chk("gap_idle_state", st, 3'd0);
      chk("gap_done", done, 1'b1);

      // RUN from IDLE, halt on 10th unstalled cycle, drain 4
      cmd_valid = 1'b1; cmd = RUN;
      tick();
      cmd_valid = 1'b0;
      chk("run_clear0_prst", prst, 1'b1);
      tick();
      chk("run_clear1_state", st, 3'd2);
      tick();
      chk("run_state", st, 3'd3);
      chk("run_stall", stall, 1'b0);
      chk("run_re", re, 1'b1);
      chk("run_count0", count, 32'd0);
      for (int k = 1; k <= 10; k++) begin
         halt_det = (k == 10);
         tick();
      end
      halt_det = 1'b0;
      chk("drain_state", st, 3'd5);
      chk("drain_count10", count, 32'd10);
      for (int d = 1; d <= 3; d++) begin
         tick();
         chk($sformatf("drain%0d_state", d), st, 3'd5);
      end
      tick();
      chk("halted_state", st, 3'd6);
      chk("halted_count", count, 32'd14);
      chk("halted_stall", stall, 1'b1);
      chk("halted_re", re, 1'b0);
      chk("halted_done", done, 1'b1);

      // STEP twice from HALTED
      for (int s = 0; s < 2; s++) begin
         cmd_valid = 1'b1; cmd = STEP;
         tick();
         cmd_valid = 1'b0;
         chk($sformatf("step%0d_state", s), st, 3'd4);
         chk($sformatf("step%0d_stall", s), stall, 1'b0);
         tick();
         chk($sformatf("step%0d_back_stall", s), stall, 1'b1);
         chk($sformatf("step%0d_done", s), done, 1'b1);
         chk($sformatf("step%0d_count", s), count, 32'd15 + s);
         tick();
         chk($sformatf("step%0d_done_clr", s), done, 1'b0);
      end

      // RUN from HALTED goes straight to RUN; illegal STEP in RUN; HALT beats halt_detected
      cmd_valid = 1'b1; cmd = RUN;
      tick();
      chk("rerun_state", st, 3'd3);
      chk("rerun_count", count, 32'd16);
      cmd = STEP;
      tick();
      chk("rerun_err", cmd_err, 1'b1);
      chk("rerun_err_state", st, 3'd3);
      cmd = HALT; halt_det = 1'b1;
      tick();
      cmd_valid = 1'b0; halt_det = 1'b0;
      chk("haltwin_state", st, 3'd6);
      chk("haltwin_done", done, 1'b1);
      chk("haltwin_count", count, 32'd18);

      // Reset in the middle of a four-word LOAD
      cmd_valid = 1'b1; cmd = LOAD; cmd_len = 9'd4;
      tick();
      cmd_valid = 1'b0;
      word_valid = 1'b1; word = W0;
      tick();
      chk("rl_w0_addr", addr, 32'd0);
      word = W1;
      tick();
      chk("rl_w1_we", we, 1'b1);
      chk("rl_w1_addr", addr, 32'd4);
      word = W2;
      rst_n = 1'b0;
      #1;
      chk("rl_async_state", st, 3'd0);
      chk("rl_async_we", we, 1'b0);
      tick();
      chk("rl_held_we", we, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("rl_after_we", we, 1'b0);
      chk("rl_after_state", st, 3'd0);
      chk("rl_after_wrdy", word_ready, 1'b0);
      word_valid = 1'b0;

      // Long RUN: watchdog stops it at 20 when compiled in
      cmd_valid = 1'b1; cmd = RUN;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      chk("wd_run_state", st, 3'd3);
`ifdef IMEM_CTRL_WATCHDOG_EN
      begin
         int n;
         n = 0;
         while (st == 3'd3 && n < 40) begin
            tick();
            n++;
         end
      end
      chk("wd_state", st, 3'd6);
      chk("wd_count", count, 32'd20);
      chk("wd_timeout", timeout, 1'b1);
      chk("wd_done", done, 1'b1);
`else
      repeat (25) tick();
      chk("nowd_state", st, 3'd3);
      chk("nowd_count", count, 32'd25);
      chk("nowd_timeout", timeout, 1'b0);
      cmd_valid = 1'b1; cmd = HALT;
      tick();
      cmd_valid = 1'b0;
      chk("nowd_halt_state", st, 3'd6);
      chk("nowd_halt_count", count, 32'd26);
`endif
      cmd_valid = 1'b1; cmd = STEP;
      tick();
      cmd_valid = 1'b0;
      chk("to_clear_state", st, 3'd4);
      chk("to_clear_flag", timeout, 1'b0);
      tick();
      chk("to_clear_back", st, 3'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
